// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_pkg : shared constants and types for the two-requester RAM arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int MEM_ARB_NREQ   = 2;
    localparam int MEM_ARB_AWIDTH = 8;
    localparam int MEM_ARB_DWIDTH = 8;

    typedef logic [0:0] req_id_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter_if : requester handshakes, response lanes and RAM port bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH    = MEM_ARB_AWIDTH,
    parameter int DWIDTH    = MEM_ARB_DWIDTH,
    parameter int NUM_BYTES = DWIDTH / 8
) ();

    logic              req0_valid, req1_valid;
    logic              req0_we,    req1_we;
    logic [AWIDTH-1:0] req0_addr,  req1_addr;
    logic [DWIDTH-1:0] req0_wdata, req1_wdata;
    logic              req0_ready, req1_ready;
    logic              rsp0_valid, rsp1_valid;
    logic [DWIDTH-1:0] rsp0_rdata, rsp1_rdata;

    logic                 mem_en;
    logic [NUM_BYTES-1:0] mem_wbe;
    logic [AWIDTH-1:0]    mem_addr;
    logic [DWIDTH-1:0]    mem_d;
    logic [DWIDTH-1:0]    mem_q;

    logic [1:0]           grant_leds;

    // Arbiter side
    modport slave (
        input  req0_valid, req1_valid, req0_we, req1_we,
        input  req0_addr, req1_addr, req0_wdata, req1_wdata,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp0_rdata, rsp1_rdata,
        output mem_en, mem_wbe, mem_addr, mem_d,
        input  mem_q,
        output grant_leds
    );

    // Requesters and RAM side
    modport master (
        output req0_valid, req1_valid, req0_we, req1_we,
        output req0_addr, req1_addr, req0_wdata, req1_wdata,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp0_rdata, rsp1_rdata,
        input  mem_en, mem_wbe, mem_addr, mem_d,
        output mem_q,
        input  grant_leds
    );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arb_picker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_picker : tie-break for two requesters; MEM_ARB_ROUND_ROBIN_EN selects
// round-robin (ptr register), otherwise requester 0 has fixed priority.  Rev 1.0
// ----------------------------------------------------------------------------
module mem_arb_picker
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  wire logic                    clk,
    input  wire logic                    rst,
`endif
    input  wire logic                    valid0_i,
    input  wire logic                    valid1_i,
    input  wire logic                    accept_i,
    output logic [MEM_ARB_NREQ-1:0]      grant_o,
    output req_id_t                      winner_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    req_id_t ptr_q, ptr_d;

    always_comb begin
        if (valid0_i && valid1_i) winner_o = ptr_q;
        else if (valid1_i)        winner_o = 1'b1;
        else                      winner_o = 1'b0;
        // Loser of this cycle's tie gets priority next time
        ptr_d = accept_i ? ~winner_o : ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end
`else
    always_comb begin
        winner_o = valid1_i && !valid0_i;
    end
`endif

    always_comb begin
        grant_o = '0;
        if (accept_i) grant_o = winner_o[0] ? 2'b10 : 2'b01;
    end

endmodule : mem_arb_picker
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter : shares one 256x8 SYNC_RAM_WBE port between two requesters and
// routes 1-cycle read data back.  Option: MEM_ARB_ROUND_ROBIN_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH    = MEM_ARB_AWIDTH,
    parameter int DWIDTH    = MEM_ARB_DWIDTH,
    parameter int NUM_BYTES = DWIDTH / 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_arbiter_if.slave  bus
);

    logic                    accept;
    logic [MEM_ARB_NREQ-1:0] grant;
    req_id_t                 win;
    logic                    win_we;
    logic [AWIDTH-1:0]       win_addr;
    logic [DWIDTH-1:0]       win_wdata;

    logic    pend_valid_q, pend_valid_d;
    req_id_t pend_id_q,    pend_id_d;
    req_id_t last_win_q,   last_win_d;

    // Gating with rst keeps ready/mem_en low while reset is held
    assign accept = (bus.req0_valid || bus.req1_valid) && !rst;

    mem_arb_picker u_picker (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .clk      (clk),
        .rst      (rst),
`endif
        .valid0_i (bus.req0_valid),
        .valid1_i (bus.req1_valid),
        .accept_i (accept),
        .grant_o  (grant),
        .winner_o (win)
    );

    always_comb begin
        win_we    = win[0] ? bus.req1_we    : bus.req0_we;
        win_addr  = win[0] ? bus.req1_addr  : bus.req0_addr;
        win_wdata = win[0] ? bus.req1_wdata : bus.req0_wdata;

        pend_valid_d = accept && !win_we;
        pend_id_d    = pend_valid_d ? win : pend_id_q;
        last_win_d   = accept ? win : last_win_q;
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

    assign bus.mem_en   = accept;
    assign bus.mem_wbe  = {NUM_BYTES{accept && win_we}};
    assign bus.mem_addr = accept ? win_addr  : '0;
    assign bus.mem_d    = accept ? win_wdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_id_q    <= 1'b0;
            last_win_q   <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
            last_win_q   <= last_win_d;
        end
    end

    assign bus.rsp0_valid = pend_valid_q && (pend_id_q == 1'b0);
    assign bus.rsp1_valid = pend_valid_q && (pend_id_q == 1'b1);
    assign bus.rsp0_rdata = bus.rsp0_valid ? bus.mem_q : '0;
    assign bus.rsp1_rdata = bus.rsp1_valid ? bus.mem_q : '0;

    assign bus.grant_leds = {last_win_q[0], pend_valid_q};

endmodule : mem_arbiter
`default_nettype wire
